// File: rtl/rat_io_periph_if.sv
// Port bus between the RAT MCU and its I/O peripheral: write strobe/data/address out, read data back.
interface rat_io_periph_if;
    logic [7:0] OUT_PORT;
    logic [7:0] PORT_ID;
    logic       IO_STRB;
    logic [7:0] IN_PORT;

    modport master (output OUT_PORT, output PORT_ID, output IO_STRB, input IN_PORT);
    modport slave  (input OUT_PORT, input PORT_ID, input IO_STRB, output IN_PORT);
endinterface

// File: rtl/rat_io_periph.sv
// RAT MCU I/O peripheral: addressed output registers, read mux, debounced button,
// 16-bit reload timer and a pulse-stretched interrupt request with write-1-to-clear pending bits.
module rat_io_periph #(
    parameter int DB_CYCLES  = 50000,
    parameter int INTR_PULSE = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    rat_io_periph_if.slave      bus,
    input  logic [7:0]          SWITCHES,
    input  logic                BTN_INT,
    output logic                INTR,
    output logic [7:0]          LEDS,
    output logic [7:0]          SSEG_VAL
);
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int PW  = (INTR_PULSE > 0) ? $clog2(INTR_PULSE + 1) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [PW-1:0]  P_LAST  = PW'(INTR_PULSE - 1);

    typedef enum logic [1:0] {IDLE, PULSE, WAIT_ACK} state_t;

    logic           sync1_reg, btn_s_reg, btn_db_reg;
    logic [DBW-1:0] db_cnt_reg;
    logic [7:0]     leds_reg, sseg_reg;
    logic [15:0]    tmr_reload_reg, tmr_cnt_reg;
    logic           tmr_en_reg;
    logic [1:0]     pend_reg, pend_next, pend_set, pend_clr;
    state_t         state_reg, state_next;
    logic [PW-1:0]  pcnt_reg, pcnt_next;
    logic           intr_reg;

    logic wr_a2, ack, db_done, tmr_run, tmr_evt;

    assign wr_a2   = bus.IO_STRB && (bus.PORT_ID == 8'hA2);
    assign ack     = bus.IO_STRB && (bus.PORT_ID == 8'hA3);
    assign db_done = (btn_s_reg != btn_db_reg) && (db_cnt_reg == DB_LAST);
    assign tmr_run = tmr_en_reg && (tmr_reload_reg != 16'd0);
    assign tmr_evt = tmr_run && (tmr_cnt_reg == 16'd0);

    assign pend_set = {tmr_evt, db_done & btn_s_reg};
    assign pend_clr = ack ? bus.OUT_PORT[1:0] : 2'b00;

    // A set event in the same cycle as its acknowledge wins, so no event is lost.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pend
            assign pend_next[gi] = pend_set[gi] | (pend_reg[gi] & ~pend_clr[gi]);
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_reg      <= 1'b0;
            btn_s_reg      <= 1'b0;
            btn_db_reg     <= 1'b0;
            db_cnt_reg     <= '0;
            leds_reg       <= 8'h00;
            sseg_reg       <= 8'h00;
            tmr_reload_reg <= 16'h0000;
            tmr_cnt_reg    <= 16'h0000;
            tmr_en_reg     <= 1'b0;
            pend_reg       <= 2'b00;
            state_reg      <= IDLE;
            pcnt_reg       <= '0;
            intr_reg       <= 1'b0;
        end else begin
            sync1_reg <= BTN_INT;
            btn_s_reg <= sync1_reg;

            if (btn_s_reg != btn_db_reg) begin
                if (db_cnt_reg == DB_LAST) begin
                    btn_db_reg <= btn_s_reg;
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + DBW'(1);
                end
            end else begin
                db_cnt_reg <= '0;
            end

            if (bus.IO_STRB) begin
                case (bus.PORT_ID)
                    8'h40:   leds_reg              <= bus.OUT_PORT;
                    8'h81:   sseg_reg              <= bus.OUT_PORT;
                    8'hA0:   tmr_reload_reg[7:0]   <= bus.OUT_PORT;
                    8'hA1:   tmr_reload_reg[15:8]  <= bus.OUT_PORT;
                    8'hA2:   tmr_en_reg            <= bus.OUT_PORT[0];
                    default: ;
                endcase
            end

            // Reload value is sampled only at load/reload, so mid-count writes wait for the next period.
            if (tmr_run) begin
                tmr_cnt_reg <= tmr_evt ? tmr_reload_reg : tmr_cnt_reg - 16'd1;
            end else if (wr_a2 && bus.OUT_PORT[0] && !tmr_en_reg) begin
                tmr_cnt_reg <= tmr_reload_reg;
            end

            pend_reg  <= pend_next;
            state_reg <= state_next;
            pcnt_reg  <= pcnt_next;
            intr_reg  <= (state_next == PULSE);
        end
    end

    always_comb begin
        state_next = state_reg;
        pcnt_next  = pcnt_reg;
        case (state_reg)
            IDLE: begin
                if (pend_reg != 2'b00) begin
                    state_next = PULSE;
                    pcnt_next  = P_LAST;
                end
            end
            PULSE: begin
                if (pcnt_reg == '0) state_next = WAIT_ACK;
                else                pcnt_next  = pcnt_reg - PW'(1);
            end
            WAIT_ACK: begin
                // Any acknowledge that leaves a source pending re-requests service.
                if (pend_next == 2'b00) begin
                    state_next = IDLE;
                end else if (ack) begin
                    state_next = PULSE;
                    pcnt_next  = P_LAST;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.IN_PORT = 8'h00;
        case (bus.PORT_ID)
            8'h20:   bus.IN_PORT = SWITCHES;
            8'hFF:   bus.IN_PORT = {7'b0, btn_db_reg};
            8'h30:   bus.IN_PORT = {6'b0, pend_reg};
            8'h40:   bus.IN_PORT = leds_reg;
            8'h81:   bus.IN_PORT = sseg_reg;
            8'hA2:   bus.IN_PORT = {7'b0, tmr_en_reg};
            default: bus.IN_PORT = 8'h00;
        endcase
    end

    assign INTR     = intr_reg;
    assign LEDS     = leds_reg;
    assign SSEG_VAL = sseg_reg;
endmodule

// File: tb/tb_rat_io_periph.sv
// Bench for rat_io_periph: directed scenarios plus random bus/button traffic against a behavioural model.
module tb_rat_io_periph;
    localparam int DB = 4;
    localparam int PL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] switches;
    logic       btn;
    logic       intr;
    logic [7:0] leds, sseg;

    rat_io_periph_if bus();

    rat_io_periph #(.DB_CYCLES(DB), .INTR_PULSE(PL)) dut (
        .CLK(clk), .RESET(rst), .bus(bus.slave), .SWITCHES(switches),
        .BTN_INT(btn), .INTR(intr), .LEDS(leds), .SSEG_VAL(sseg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          started = 0;
    bit          m_s1, m_s2, m_db;
    int          m_run;
    logic [7:0]  m_leds, m_sseg;
    logic [15:0] m_rel, m_cnt;
    bit          m_en;
    logic [1:0]  m_pend, m_pnew;
    int          m_pulse_left;   // cycles of INTR still to be driven high
    bit          m_waiting;      // pulse done, waiting for acknowledge
    bit          m_rise, m_evt, m_ack;

    function automatic logic [7:0] m_read(input logic [7:0] id);
        case (id)
            8'h20:   return switches;
            8'hFF:   return {7'b0, m_db};
            8'h30:   return {6'b0, m_pend};
            8'h40:   return m_leds;
            8'h81:   return m_sseg;
            8'hA2:   return {7'b0, m_en};
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
            m_leds = 0; m_sseg = 0; m_rel = 0; m_cnt = 0; m_en = 0;
            m_pend = 0; m_pulse_left = 0; m_waiting = 0;
        end else begin
            // debounced value follows the synced button once it has differed for DB straight cycles
            m_rise = 0;
            if (m_s2 != m_db) begin
                m_run++;
                if (m_run == DB) begin
                    m_db = m_s2; m_run = 0; m_rise = m_db;
                end
            end else m_run = 0;
            m_s2 = m_s1;
            m_s1 = btn;

            m_evt = 0;
            if (m_en && m_rel != 0) begin
                if (m_cnt == 0) begin m_evt = 1; m_cnt = m_rel; end
                else m_cnt = m_cnt - 1;
            end else if (bus.IO_STRB && bus.PORT_ID == 8'hA2 && bus.OUT_PORT[0] && !m_en)
                m_cnt = m_rel;

            m_ack  = bus.IO_STRB && bus.PORT_ID == 8'hA3;
            m_pnew = m_pend;
            if (m_ack)  m_pnew = m_pnew & ~bus.OUT_PORT[1:0];
            if (m_rise) m_pnew[0] = 1'b1;
            if (m_evt)  m_pnew[1] = 1'b1;

            if (m_pulse_left > 0) begin
                m_pulse_left--;
                if (m_pulse_left == 0) m_waiting = 1;
            end else if (m_waiting) begin
                if (m_pnew == 0) m_waiting = 0;
                else if (m_ack) begin m_waiting = 0; m_pulse_left = PL; end
            end else if (m_pend != 0) m_pulse_left = PL;

            if (bus.IO_STRB) begin
                case (bus.PORT_ID)
                    8'h40: m_leds = bus.OUT_PORT;
                    8'h81: m_sseg = bus.OUT_PORT;
                    8'hA0: m_rel[7:0]  = bus.OUT_PORT;
                    8'hA1: m_rel[15:8] = bus.OUT_PORT;
                    8'hA2: m_en = bus.OUT_PORT[0];
                    default: ;
                endcase
            end
            m_pend = m_pnew;
        end
    end

    // one compare process, every cycle once the model is initialised
    always @(negedge clk) begin
        if (started) begin
            check("leds", {8'h0, leds}, {8'h0, m_leds});
            check("sseg", {8'h0, sseg}, {8'h0, m_sseg});
            check("intr", {15'h0, intr}, {15'h0, (m_pulse_left > 0)});
            check("in_port", {8'h0, bus.IN_PORT}, {8'h0, m_read(bus.PORT_ID)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        bus.IO_STRB = 1'b1; bus.PORT_ID = id; bus.OUT_PORT = d;
        @(posedge clk); #1;
        bus.IO_STRB = 1'b0;
        $display("wr id=0x%02h data=0x%02h t=%0t", id, d, $time);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] id, input logic [7:0] mask,
                          input logic [7:0] exp);
        bus.PORT_ID = id;
        @(negedge clk);
        check(name, {8'h0, bus.IN_PORT & mask}, {8'h0, exp});
        @(posedge clk); #1;
    endtask

    int  n_high;
    bit  seen;
    int  r;
    logic [7:0] ids [6] = '{8'h40, 8'h81, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    logic [7:0] rids[8] = '{8'h20, 8'hFF, 8'h30, 8'h40, 8'h81, 8'hA2, 8'h55, 8'h00};

    initial begin
        rst = 1'b1; btn = 1'b0; switches = 8'h3C;
        bus.IO_STRB = 1'b0; bus.PORT_ID = 8'h00; bus.OUT_PORT = 8'h00;
        idle(3);
        rst = 1'b0;
        rd_chk("reset_pend", 8'h30, 8'hFF, 8'h00);
        check("reset_leds", {8'h0, leds}, 16'h0000);
        check("reset_intr", {15'h0, intr}, 16'h0000);

        wr(8'h40, 8'hA5);
        check("leds_a5", {8'h0, leds}, 16'h00A5);
        rd_chk("rd_leds", 8'h40, 8'hFF, 8'hA5);
        rd_chk("rd_unmapped", 8'h55, 8'hFF, 8'h00);
        rd_chk("rd_switches", 8'h20, 8'hFF, 8'h3C);

        // short glitch must not pass the debouncer
        btn = 1'b1; idle(2); btn = 1'b0; idle(10);
        rd_chk("glitch_pend", 8'h30, 8'hFF, 8'h00);

        // held press: one pending bit, INTR high for exactly PL cycles
        btn = 1'b1; n_high = 0;
        repeat (25) begin @(negedge clk); if (intr) n_high++; end
        @(posedge clk); #1;
        check("btn_intr_len", 16'(n_high), 16'd4);
        rd_chk("btn_pend", 8'h30, 8'hFF, 8'h01);
        rd_chk("btn_db", 8'hFF, 8'hFF, 8'h01);
        wr(8'hA3, 8'h01);
        btn = 1'b0; idle(12);
        rd_chk("release_pend", 8'h30, 8'hFF, 8'h00);

        // timer period RELOAD+1, events collide with acks of the same bit
        wr(8'hA0, 8'h03); wr(8'hA1, 8'h00);
        wr(8'hA2, 8'h01);
        idle(3);
        wr(8'hA3, 8'h02);
        idle(3);
        wr(8'hA3, 8'h02);
        rd_chk("tmr_set_beats_ack", 8'h30, 8'h02, 8'h02);
        wr(8'hA3, 8'h02);
        rd_chk("tmr_ack_clears", 8'h30, 8'h02, 8'h00);
        rd_chk("tmr_en_rd", 8'hA2, 8'hFF, 8'h01);

        // both sources pending while the timer keeps running
        btn = 1'b1; idle(15);
        wr(8'hA3, 8'h01);
        idle(20);
        wr(8'hA2, 8'h00); wr(8'hA3, 8'h03);
        btn = 1'b0; idle(15);
        wr(8'hA3, 8'h03); idle(2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30) begin
                logic [7:0] id, d;
                id = ids[$urandom_range(0, 5)];
                d  = 8'($urandom);
                if (id == 8'hA0) d = 8'($urandom_range(0, 7));
                if (id == 8'hA1) d = ($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00;
                wr(id, d);
            end else if (r < 36) begin
                btn = ~btn; idle(1);
            end else if (r < 38) begin
                rst = 1'b1; idle(1); rst = 1'b0;
            end else begin
                if (r > 95) switches = 8'($urandom);
                bus.PORT_ID = rids[$urandom_range(0, 7)];
                idle(1);
            end
        end

        // reset in the middle of an interrupt pulse
        wr(8'hA2, 8'h00); wr(8'hA3, 8'h03);
        btn = 1'b0; idle(15);
        wr(8'hA3, 8'h03); wr(8'h40, 8'h3C);
        btn = 1'b1; seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (intr) seen = 1;
        end
        check("intr_seen", {15'h0, seen}, 16'h0001);
        rst = 1'b1; bus.PORT_ID = 8'h30;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_intr", {15'h0, intr}, 16'h0000);
        check("rst_leds", {8'h0, leds}, 16'h0000);
        check("rst_pend", {8'h0, bus.IN_PORT}, 16'h0000);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
